seq_detector_prog: RTL and testbench

- Parametrised serial pattern detector; successor to the fixed-pattern 4-bit Mealy detectors in the FSM library.
- Pattern length is a parameter. Pattern value is runtime-loadable.
- Supports overlapping and non-overlapping match modes, a qualified input bit stream, and a saturating match counter.
- Sits on a serial bit stream (UART/line-decoder output) and flags framing or sync words to downstream control logic.

---
 rtl/seq_detector_prog.sv | 96 +++++++++
 tb/tb_seq_detector_prog.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_prog.sv
// Programmable serial pattern detector with overlap control, a qualified input stream
// and a saturating match counter. Define SEQ_DET_MASK_EN to add a per-bit compare mask.
module seq_detector_prog #(
    parameter int                 PAT_W       = 4,
    parameter logic [PAT_W-1:0]   DEFAULT_PAT = PAT_W'(4'b1010),
    parameter int                 CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din,
    input  logic               din_vld,
    input  logic               overlap,
    input  logic               cfg_load,
    input  logic [PAT_W-1:0]   cfg_pat,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0]   cfg_mask,
`endif
    input  logic               cnt_clr,
    output logic               dout,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cnt_sat
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [FILL_W-1:0] FILL_THR = FILL_W'(PAT_W - 1);

    logic [PAT_W-1:0]  pattern;
    logic [PAT_W-1:0]  history;
    logic [FILL_W-1:0] fill;
    logic [PAT_W-1:0]  h_next;
    logic [PAT_W-1:0]  diff;
    logic              accept;
    logic              match;
    logic [CNT_W-1:0]  cnt_next;

`ifdef SEQ_DET_MASK_EN
    logic [PAT_W-1:0]  mask;
`endif

    assign h_next = {history[PAT_W-2:0], din};
    assign accept = din_vld && !cfg_load;

`ifdef SEQ_DET_MASK_EN
    assign diff = (h_next ^ pattern) & mask;
`else
    assign diff = h_next ^ pattern;
`endif

    // The completing bit is the one that brings fill to PAT_W, hence the >= PAT_W-1 test.
    assign match = accept && (fill >= FILL_THR) && (diff == '0);

    // Clear wins over a same-cycle match; the count sticks once it reaches all ones.
    always_comb begin
        cnt_next = match_cnt;
        if (cnt_clr) begin
            cnt_next = '0;
        end else if (match && !(&match_cnt)) begin
            cnt_next = match_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pattern   <= DEFAULT_PAT;
            history   <= '0;
            fill      <= '0;
            dout      <= 1'b0;
            match_cnt <= '0;
            cnt_sat   <= 1'b0;
`ifdef SEQ_DET_MASK_EN
            mask      <= '1;
`endif
        end else begin
            dout      <= match;
            match_cnt <= cnt_next;
            cnt_sat   <= &cnt_next;
            if (cfg_load) begin
                pattern <= cfg_pat;
                history <= '0;
                fill    <= '0;
`ifdef SEQ_DET_MASK_EN
                mask    <= cfg_mask;
`endif
            end else if (din_vld) begin
                history <= h_next;
                if (match) begin
                    fill <= overlap ? FILL_MAX : '0;
                end else if (fill != FILL_MAX) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_seq_detector_prog.sv
// Bench for seq_detector_prog: two instances (CNT_W=8 and CNT_W=2) share one stimulus
// stream and are compared each cycle against a queue-based model of the detection rules.
module tb_seq_detector_prog;

    localparam int PAT_W = 4;

    logic       clk = 1'b0;
    logic       rst_n, din, din_vld, overlap, cfg_load, cnt_clr;
    logic [3:0] cfg_pat;
    logic [3:0] cfg_mask;
    logic       dout_a, sat_a, dout_b, sat_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    int checks = 0;
    int errors = 0;

    // Model state: accepted bits since the last reset / load / non-overlapping match.
    logic [3:0] m_pat;
    int         m_q[$];
    bit         m_dout;
    int         m_cnt_a, m_cnt_b;

    always #5 clk = ~clk;

    seq_detector_prog #(.PAT_W(4), .DEFAULT_PAT(4'b1010), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cnt_clr(cnt_clr), .dout(dout_a), .match_cnt(cnt_a), .cnt_sat(sat_a)
    );

    seq_detector_prog #(.PAT_W(4), .DEFAULT_PAT(4'b1010), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld), .overlap(overlap),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat),
`ifdef SEQ_DET_MASK_EN
        .cfg_mask(cfg_mask),
`endif
        .cnt_clr(cnt_clr), .dout(dout_b), .match_cnt(cnt_b), .cnt_sat(sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic d, input logic v, input logic o,
                              input logic l, input logic [3:0] p, input logic c);
        bit hit;
        int val;
        hit = 1'b0;
        if (!r) begin
            m_pat = 4'b1010;
            m_q.delete();
            m_dout = 1'b0;
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else begin
            if (l) begin
                m_pat = p;
                m_q.delete();
            end else if (v) begin
                m_q.push_back(int'(d));
                if (m_q.size() >= PAT_W) begin
                    val = 0;
                    for (int i = m_q.size() - PAT_W; i < m_q.size(); i++)
                        val = (val << 1) | m_q[i];
                    hit = (val == int'(m_pat));
                end
                if (hit && !o) m_q.delete();
                while (m_q.size() > PAT_W) void'(m_q.pop_front());
            end
            m_dout = hit;
            if (c) begin
                m_cnt_a = 0;
                m_cnt_b = 0;
            end else if (hit) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3) m_cnt_b++;
            end
        end
    endtask

    task automatic step(input logic r, input logic d, input logic v, input logic o,
                        input logic l, input logic [3:0] p, input logic c);
        rst_n = r; din = d; din_vld = v; overlap = o;
        cfg_load = l; cfg_pat = p; cnt_clr = c;
        @(posedge clk);
        model_edge(r, d, v, o, l, p, c);
        #1;
        chk("dout_a", 32'(dout_a), 32'(m_dout));
        chk("cnt_a",  32'(cnt_a),  32'(m_cnt_a));
        chk("sat_a",  32'(sat_a),  32'(m_cnt_a == 255));
        chk("dout_b", 32'(dout_b), 32'(m_dout));
        chk("cnt_b",  32'(cnt_b),  32'(m_cnt_b));
        chk("sat_b",  32'(sat_b),  32'(m_cnt_b == 3));
    endtask

    initial begin
        cfg_mask = 4'hF;

        // reset held two cycles with din toggling
        step(0, 1, 1, 1, 0, 4'h0, 0);
        step(0, 0, 1, 1, 0, 4'h0, 0);
        chk("rst_dout", 32'(dout_a), 32'(0));
        chk("rst_cnt",  32'(cnt_a),  32'(0));

        // partial 1,0,1 then reset; the 0 after release must not complete 1010
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(1, 0, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(0, 0, 1, 1, 0, 4'h0, 0);
        step(1, 0, 1, 1, 0, 4'h0, 0);
        chk("rst_span_dout", 32'(dout_a), 32'(0));

        // overlap: 1,0,1,0,1,0 -> two matches
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(1, 0, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(1, 0, 1, 1, 0, 4'h0, 0);
        chk("ovl_dout4", 32'(dout_a), 32'(1));
        step(1, 1, 1, 1, 0, 4'h0, 0);
        chk("ovl_dout5", 32'(dout_a), 32'(0));
        step(1, 0, 1, 1, 0, 4'h0, 0);
        chk("ovl_dout6", 32'(dout_a), 32'(1));
        chk("ovl_cnt",   32'(cnt_a),  32'(2));

        // non-overlap: 1,0,1,0,1,0,1,0 -> matches at bits 4 and 8 only
        step(1, 0, 0, 0, 1, 4'b1010, 1);
        for (int i = 0; i < 8; i++) begin
            step(1, (i % 2) == 0, 1, 0, 0, 4'h0, 0);
            if (i == 5) chk("novl_dout6", 32'(dout_a), 32'(0));
        end
        chk("novl_dout8", 32'(dout_a), 32'(1));
        chk("novl_cnt",   32'(cnt_a),  32'(2));

        // gapped: 1,0, three idle cycles, 1,0
        step(1, 0, 0, 1, 1, 4'b1010, 1);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(1, 0, 1, 1, 0, 4'h0, 0);
        step(1, 1, 0, 1, 0, 4'h0, 0);
        step(1, 0, 0, 1, 0, 4'h0, 0);
        step(1, 1, 0, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(1, 0, 1, 1, 0, 4'h0, 0);
        chk("gap_dout", 32'(dout_a), 32'(1));
        chk("gap_cnt",  32'(cnt_a),  32'(1));

        // runtime load swallows the completing bit
        step(1, 0, 0, 1, 1, 4'b1010, 1);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(1, 0, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(1, 0, 1, 1, 1, 4'b0110, 0);
        chk("load_nodout", 32'(dout_a), 32'(0));
        step(1, 0, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(1, 1, 1, 1, 0, 4'h0, 0);
        step(1, 0, 1, 1, 0, 4'h0, 0);
        chk("load_dout", 32'(dout_a), 32'(1));

        // saturation on the 2-bit counter with all-ones pattern, then clear vs match
        step(1, 0, 0, 1, 1, 4'b1111, 1);
        for (int i = 0; i < 8; i++) step(1, 1, 1, 1, 0, 4'h0, 0);
        chk("sat_cnt_b", 32'(cnt_b), 32'(3));
        chk("sat_flag_b", 32'(sat_b), 32'(1));
        chk("sat_cnt_a", 32'(cnt_a), 32'(5));
        step(1, 1, 1, 1, 0, 4'h0, 1);
        chk("clr_cnt_b",  32'(cnt_b),  32'(0));
        chk("clr_flag_b", 32'(sat_b),  32'(0));
        chk("clr_dout_b", 32'(dout_b), 32'(1));

        // zero pattern, non-overlapping
        step(1, 0, 0, 0, 1, 4'b0000, 1);
        for (int i = 0; i < 9; i++) step(1, 0, 1, 0, 0, 4'h0, 0);
        chk("zero_cnt", 32'(cnt_a), 32'(2));

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, 24) == 0,
                 4'($urandom),
                 $urandom_range(0, 39) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
